// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Purpose:
//   Load/store unit front end sitting between a pipeline and a 32-bit
//   word-organised memory. It accepts one request at a time, and for each
//   request it:
//     - converts the byte address into a word address plus byte enables,
//     - shifts store data into the addressed byte lanes,
//     - selects and sign/zero-extends load data.
//   A request is misaligned when it crosses a word boundary: a half at
//   offset 3, or a word at any non-zero offset.
//
// Configuration macro:
//   MISALIGNED_SPLIT_EN
//     Defined:   a misaligned request becomes two word accesses, the
//                aligned word and the next word (wrapping at the top of the
//                address space). The two results are merged.
//     Undefined: a misaligned request is answered one cycle after
//                acceptance with misalign_o = 1 and no memory access.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_valid_i/ready  request handshake (ready only while idle)
//   req_we_i           1 = store, 0 = load
//   addr_i, wdata_i    byte address, right-aligned store data
//   mem_type_i         01 byte, 10 half, 00/11 word
//   mem_sign_i         0 sign-extend, 1 zero-extend (loads)
//   rsp_valid_o        one-cycle completion pulse
//   rdata_o            extended load data (0 for stores / when idle)
//   misalign_o         misalignment error, qualified by rsp_valid_o
//   mem_req_o ..       word-aligned memory request, held until mem_ack_i
//   mem_ack_i          access complete, mem_rdata_i valid with it
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [ADDR_WIDTH-1:0] wdata_i,
    input  logic [1:0]            mem_type_i,
    input  logic                  mem_sign_i,
    output logic                  rsp_valid_o,
    output logic [ADDR_WIDTH-1:0] rdata_o,
    output logic                  misalign_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [ADDR_WIDTH-1:0] mem_rdata_i
);

`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        RESP = 2'd3
    } state_t;

    // Byte-enable pattern of the access size before shifting into its lane.
    function automatic logic [3:0] base_be(input logic [1:0] mtype);
        logic [3:0] be;
        case (mtype)
            2'b01:   be = 4'b0001;
            2'b10:   be = 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] mtype,
                                           input logic [1:0] off);
        logic mis;
        case (mtype)
            2'b01:   mis = 1'b0;
            2'b10:   mis = (off == 2'd3);
            default: mis = (off != 2'd0);
        endcase
        return mis;
    endfunction

    // The two memory words are viewed as one little-endian double word;
    // shifting it down by the byte offset puts the addressed data at bit 0
    // whether or not the access was split.
    function automatic logic [ADDR_WIDTH-1:0] load_extract(
        input logic [2*ADDR_WIDTH-1:0] pair,
        input logic [1:0]              off,
        input logic [1:0]              mtype,
        input logic                    zext
    );
        logic [2*ADDR_WIDTH-1:0] sh;
        logic [ADDR_WIDTH-1:0]   res;
        sh = pair >> {off, 3'b000};
        case (mtype)
            2'b01: begin
                if (zext) res = {{(ADDR_WIDTH-8){1'b0}}, sh[7:0]};
                else      res = {{(ADDR_WIDTH-8){sh[7]}}, sh[7:0]};
            end
            2'b10: begin
                if (zext) res = {{(ADDR_WIDTH-16){1'b0}}, sh[15:0]};
                else      res = {{(ADDR_WIDTH-16){sh[15]}}, sh[15:0]};
            end
            default: res = sh[ADDR_WIDTH-1:0];
        endcase
        return res;
    endfunction

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [1:0]              off_q, off_d;
    logic [1:0]              type_q, type_d;
    logic                    zext_q, zext_d;
    logic                    need2_q, need2_d;
    logic [ADDR_WIDTH-1:0]   lo_word_q, lo_word_d;
    logic [ADDR_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    misalign_q, misalign_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]              mem_be_q, mem_be_d;
    logic [ADDR_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]              be_hi_q, be_hi_d;
    logic [ADDR_WIDTH-1:0]   wdata_hi_q, wdata_hi_d;

    // Request decoding. Byte enables and store data are shifted as a
    // double word so that lanes pushed past byte 3 land in the upper half,
    // ready to be used by the second access of a split request.
    logic [1:0]              req_off;
    logic                    req_mis;
    logic [7:0]              req_be_pair;
    logic [2*ADDR_WIDTH-1:0] req_wdata_pair;
    logic                    ack_seen;

    always_comb begin
        req_off        = addr_i[1:0];
        req_mis        = is_misaligned(mem_type_i, req_off);
        req_be_pair    = {4'b0000, base_be(mem_type_i)} << req_off;
        req_wdata_pair = {{ADDR_WIDTH{1'b0}}, wdata_i} << {req_off, 3'b000};
        ack_seen       = mem_ack_i & mem_req_q;
    end

    // Next-state and datapath. The mem_* registers are loaded when an
    // access starts and left untouched until its acknowledge, which is what
    // keeps the memory interface stable across wait states. They are
    // cleared when the last access completes so the memory side is quiet
    // whenever no access is in progress.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        off_d       = off_q;
        type_d      = type_q;
        zext_d      = zext_q;
        need2_d     = need2_q;
        lo_word_d   = lo_word_q;
        rdata_d     = rdata_q;
        misalign_d  = misalign_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        be_hi_d     = be_hi_q;
        wdata_hi_d  = wdata_hi_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    off_d   = req_off;
                    type_d  = mem_type_i;
                    zext_d  = mem_sign_i;
                    rdata_d = '0;
                    if (req_mis && !SPLIT_EN) begin
                        state_d    = RESP;
                        misalign_d = 1'b1;
                        need2_d    = 1'b0;
                    end else begin
                        state_d     = ACC1;
                        misalign_d  = 1'b0;
                        need2_d     = req_mis;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we_i;
                        mem_addr_d  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
                        mem_be_d    = req_be_pair[3:0];
                        mem_wdata_d = req_wdata_pair[ADDR_WIDTH-1:0];
                        be_hi_d     = req_be_pair[7:4];
                        wdata_hi_d  = req_wdata_pair[2*ADDR_WIDTH-1:ADDR_WIDTH];
                    end
                end
            end

            ACC1: begin
                if (ack_seen) begin
                    lo_word_d = mem_rdata_i;
                    if (need2_q) begin
                        // Address addition wraps naturally at the top word.
                        state_d     = ACC2;
                        mem_addr_d  = mem_addr_q + ADDR_WIDTH'(4);
                        mem_be_d    = be_hi_q;
                        mem_wdata_d = wdata_hi_q;
                    end else begin
                        state_d     = RESP;
                        rdata_d     = we_q ? '0 :
                                      load_extract({{ADDR_WIDTH{1'b0}}, mem_rdata_i},
                                                   off_q, type_q, zext_q);
                        mem_req_d   = 1'b0;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = '0;
                        mem_be_d    = '0;
                        mem_wdata_d = '0;
                    end
                end
            end

            ACC2: begin
                if (ack_seen) begin
                    state_d     = RESP;
                    rdata_d     = we_q ? '0 :
                                  load_extract({mem_rdata_i, lo_word_q},
                                               off_q, type_q, zext_q);
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_be_d    = '0;
                    mem_wdata_d = '0;
                end
            end

            RESP: begin
                state_d    = IDLE;
                rdata_d    = '0;
                misalign_d = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset abandons any access in flight:
    // the controller returns to IDLE with the memory request dropped, so a
    // late acknowledge finds nothing waiting for it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            off_q       <= 2'b00;
            type_q      <= 2'b00;
            zext_q      <= 1'b0;
            need2_q     <= 1'b0;
            lo_word_q   <= '0;
            rdata_q     <= '0;
            misalign_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            be_hi_q     <= 4'b0000;
            wdata_hi_q  <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            off_q       <= off_d;
            type_q      <= type_d;
            zext_q      <= zext_d;
            need2_q     <= need2_d;
            lo_word_q   <= lo_word_d;
            rdata_q     <= rdata_d;
            misalign_q  <= misalign_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            be_hi_q     <= be_hi_d;
            wdata_hi_q  <= wdata_hi_d;
        end
    end

    // Response fields are additionally gated by rsp_valid_o so that they
    // read as zero outside the single response cycle.
    always_comb begin
        req_ready_o = (state_q == IDLE);
        rsp_valid_o = (state_q == RESP);
        rdata_o     = rsp_valid_o ? rdata_q : '0;
        misalign_o  = rsp_valid_o & misalign_q;
        mem_req_o   = mem_req_q;
        mem_we_o    = mem_we_q;
        mem_addr_o  = mem_addr_q;
        mem_be_o    = mem_be_q;
        mem_wdata_o = mem_wdata_q;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Self-checking bench for mem_access_ctrl. A behavioural model predicts,
// for every request, the memory accesses, the byte enables, the store
// lanes and the extended load result. It works byte by byte from the
// access size and offset. Stimulus is a mix of directed cases and random
// requests with random wait states. The bench follows MISALIGNED_SPLIT_EN
// in the same way as the design.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [1:0]  mem_type_i = '0;
    logic        mem_sign_i = 1'b0;
    logic        rsp_valid_o;
    logic [31:0] rdata_o;
    logic        misalign_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .mem_type_i  (mem_type_i),
        .mem_sign_i  (mem_sign_i),
        .rsp_valid_o (rsp_valid_o),
        .rdata_o     (rdata_o),
        .misalign_o  (misalign_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_be_o    (mem_be_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Runs one request end to end and checks every cycle of it against the
    // model. rd0/rd1 are the words the memory returns. With hold_valid set,
    // req_valid_i stays high carrying unrelated fields after acceptance; the
    // design must ignore them until it is idle again.
    task automatic run_txn(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] mtype,
                           input logic sign, input int wait0, input int wait1,
                           input logic [31:0] rd0, input logic [31:0] rd1,
                           input bit hold_valid,
                           output logic [31:0] got_rdata, output logic got_mis,
                           output logic [31:0] got_addr1);
        int          off, nbytes, n_acc;
        bit          mis;
        logic [31:0] exp_addr [2];
        logic [3:0]  exp_be [2];
        logic [31:0] exp_wd [2];
        logic [31:0] rd [2];
        int          waits [2];
        logic [63:0] wpair;
        logic [7:0]  bepair;
        logic [7:0]  bytes [8];
        logic [31:0] exp_rdata;

        off    = int'(addr[1:0]);
        nbytes = (mtype == 2'b01) ? 1 : (mtype == 2'b10) ? 2 : 4;
        mis    = (off + nbytes) > 4;
        n_acc  = mis ? (SPLIT ? 2 : 0) : 1;
        wpair  = {32'h0, wdata} << (8 * off);
        bepair = 8'((1 << nbytes) - 1) << off;
        exp_addr[0] = addr & 32'hFFFF_FFFC;
        exp_addr[1] = exp_addr[0] + 32'd4;
        exp_be[0] = bepair[3:0];
        exp_be[1] = bepair[7:4];
        exp_wd[0] = wpair[31:0];
        exp_wd[1] = wpair[63:32];
        rd[0] = rd0;
        rd[1] = rd1;
        waits[0] = wait0;
        waits[1] = wait1;
        got_addr1 = 32'hDEAD_BEEF;

        for (int i = 0; i < 8; i++) bytes[i] = rd[i / 4][8 * (i % 4) +: 8];
        exp_rdata = '0;
        for (int i = 0; i < nbytes; i++) exp_rdata |= 32'(bytes[off + i]) << (8 * i);
        if (!sign && nbytes < 4 && exp_rdata[8 * nbytes - 1])
            exp_rdata |= ~((32'h1 << (8 * nbytes)) - 32'h1);
        if (we) exp_rdata = '0;

        req_valid_i = 1'b1;
        req_we_i    = we;
        addr_i      = addr;
        wdata_i     = wdata;
        mem_type_i  = mtype;
        mem_sign_i  = sign;
        n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("[TB] FAIL %s ready_at_issue: got %b want 1", tag, req_ready_o); end
        @(posedge clk_i); #1;
        if (hold_valid) begin
            req_we_i   = $urandom_range(0, 1);
            addr_i     = $urandom;
            wdata_i    = $urandom;
            mem_type_i = 2'($urandom_range(0, 3));
            mem_sign_i = $urandom_range(0, 1);
        end else begin
            req_valid_i = 1'b0;
        end

        if (n_acc == 0) begin
            n_cmp++; if (rsp_valid_o !== 1'b1) begin n_err++; $display("[TB] FAIL %s mis_rsp_valid: got %b want 1", tag, rsp_valid_o); end
            n_cmp++; if (misalign_o !== 1'b1) begin n_err++; $display("[TB] FAIL %s mis_flag: got %b want 1", tag, misalign_o); end
            n_cmp++; if (rdata_o !== 32'h0) begin n_err++; $display("[TB] FAIL %s mis_rdata: got %h want 0", tag, rdata_o); end
            n_cmp++; if (mem_req_o !== 1'b0) begin n_err++; $display("[TB] FAIL %s mis_mem_req: got %b want 0", tag, mem_req_o); end
            n_cmp++; if (req_ready_o !== 1'b0) begin n_err++; $display("[TB] FAIL %s mis_ready: got %b want 0", tag, req_ready_o); end
            got_rdata = rdata_o;
            got_mis   = misalign_o;
        end else begin
            for (int k = 0; k < n_acc; k++) begin
                for (int c = 0; c <= waits[k]; c++) begin
                    n_cmp++; if (mem_req_o !== 1'b1) begin n_err++; $display("[TB] FAIL %s acc%0d_req c%0d: got %b want 1", tag, k, c, mem_req_o); end
                    n_cmp++; if (mem_we_o !== we) begin n_err++; $display("[TB] FAIL %s acc%0d_we c%0d: got %b want %b", tag, k, c, mem_we_o, we); end
                    n_cmp++; if (mem_addr_o !== exp_addr[k]) begin n_err++; $display("[TB] FAIL %s acc%0d_addr c%0d: got %h want %h", tag, k, c, mem_addr_o, exp_addr[k]); end
                    n_cmp++; if (mem_be_o !== exp_be[k]) begin n_err++; $display("[TB] FAIL %s acc%0d_be c%0d: got %b want %b", tag, k, c, mem_be_o, exp_be[k]); end
                    if (we) begin
                        n_cmp++; if (mem_wdata_o !== exp_wd[k]) begin n_err++; $display("[TB] FAIL %s acc%0d_wdata c%0d: got %h want %h", tag, k, c, mem_wdata_o, exp_wd[k]); end
                    end
                    n_cmp++; if (rsp_valid_o !== 1'b0 || rdata_o !== 32'h0 || req_ready_o !== 1'b0) begin n_err++; $display("[TB] FAIL %s acc%0d_quiet c%0d: got rsp=%b rdata=%h ready=%b want 0/0/0", tag, k, c, rsp_valid_o, rdata_o, req_ready_o); end
                    if (k == 1) got_addr1 = mem_addr_o;
                    if (c == waits[k]) begin
                        mem_ack_i   = 1'b1;
                        mem_rdata_i = rd[k];
                    end else begin
                        mem_ack_i   = 1'b0;
                        mem_rdata_i = $urandom;
                    end
                    @(posedge clk_i); #1;
                    mem_ack_i = 1'b0;
                end
            end
            n_cmp++; if (rsp_valid_o !== 1'b1) begin n_err++; $display("[TB] FAIL %s rsp_valid: got %b want 1", tag, rsp_valid_o); end
            n_cmp++; if (rdata_o !== exp_rdata) begin n_err++; $display("[TB] FAIL %s rdata: got %h want %h", tag, rdata_o, exp_rdata); end
            n_cmp++; if (misalign_o !== 1'b0) begin n_err++; $display("[TB] FAIL %s misalign: got %b want 0", tag, misalign_o); end
            n_cmp++; if (mem_req_o !== 1'b0 || req_ready_o !== 1'b0) begin n_err++; $display("[TB] FAIL %s rsp_cycle: got req=%b ready=%b want 0/0", tag, mem_req_o, req_ready_o); end
            got_rdata = rdata_o;
            got_mis   = misalign_o;
        end

        // Stray acknowledge while nothing is requested must be ignored.
        mem_ack_i = $urandom_range(0, 1);
        @(posedge clk_i); #1;
        n_cmp++; if (rsp_valid_o !== 1'b0 || rdata_o !== 32'h0 || misalign_o !== 1'b0) begin n_err++; $display("[TB] FAIL %s after_rsp: got rsp=%b rdata=%h mis=%b want 0/0/0", tag, rsp_valid_o, rdata_o, misalign_o); end
        n_cmp++; if (req_ready_o !== 1'b1 || mem_req_o !== 1'b0) begin n_err++; $display("[TB] FAIL %s back_idle: got ready=%b req=%b want 1/0", tag, req_ready_o, mem_req_o); end
        mem_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        addr_i      = 32'h0000_1234;
        wdata_i     = 32'hFFFF_FFFF;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk_i);
        #1;
        n_cmp++; if (rsp_valid_o !== 1'b0 || rdata_o !== 32'h0 || misalign_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rsp: got rsp=%b rdata=%h mis=%b want 0/0/0", rsp_valid_o, rdata_o, misalign_o); end
        n_cmp++; if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_mem_ctl: got req=%b we=%b want 0/0", mem_req_o, mem_we_o); end
        n_cmp++; if (mem_addr_o !== 32'h0 || mem_be_o !== 4'h0 || mem_wdata_o !== 32'h0) begin n_err++; $display("[TB] FAIL reset_mem_bus: got addr=%h be=%b wdata=%h want 0", mem_addr_o, mem_be_o, mem_wdata_o); end
        req_valid_i = 1'b0;
        mem_ack_i   = 1'b0;
        rst_ni      = 1'b1;
        @(posedge clk_i); #1;
        n_cmp++; if (req_ready_o !== 1'b1 || mem_req_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_release: got ready=%b req=%b want 1/0", req_ready_o, mem_req_o); end
    endtask

    task automatic test_directed();
        logic [31:0] r, a1;
        logic        m;
        run_txn("byte_sext", 1'b0, 32'h0000_0102, 32'h0, 2'b01, 1'b0, 0, 0,
                32'h1280_3456, 32'h0, 1'b0, r, m, a1);
        n_cmp++; if (r !== 32'hFFFF_FF80) begin n_err++; $display("[TB] FAIL byte_sext_value: got %h want ffffff80", r); end
        run_txn("half_store", 1'b1, 32'h0000_0202, 32'h0000_ABCD, 2'b10, 1'b0, 3, 0,
                32'h0, 32'h0, 1'b0, r, m, a1);
        n_cmp++; if (r !== 32'h0) begin n_err++; $display("[TB] FAIL half_store_rdata: got %h want 0", r); end
        run_txn("word_mis", 1'b0, 32'h0000_0301, 32'h0, 2'b00, 1'b0, 0, 1,
                32'h4433_2211, 32'h8877_6655, 1'b0, r, m, a1);
        if (SPLIT) begin
            n_cmp++; if (r !== 32'h5544_3322 || m !== 1'b0) begin n_err++; $display("[TB] FAIL word_split_value: got %h mis=%b want 55443322/0", r, m); end
            n_cmp++; if (a1 !== 32'h0000_0304) begin n_err++; $display("[TB] FAIL word_split_addr: got %h want 00000304", a1); end
        end else begin
            n_cmp++; if (m !== 1'b1 || r !== 32'h0) begin n_err++; $display("[TB] FAIL word_mis_flag: got mis=%b rdata=%h want 1/0", m, r); end
        end
        run_txn("half_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0, 2'b10, 1'b1, 1, 0,
                32'hA1B2_C3D4, 32'h0000_00E5, 1'b0, r, m, a1);
        if (SPLIT) begin
            n_cmp++; if (a1 !== 32'h0000_0000 || r !== 32'h0000_E5A1) begin n_err++; $display("[TB] FAIL half_wrap_split: got addr=%h rdata=%h want 0/0000e5a1", a1, r); end
        end else begin
            n_cmp++; if (m !== 1'b1) begin n_err++; $display("[TB] FAIL half_wrap_mis: got %b want 1", m); end
        end
        run_txn("half_zext", 1'b0, 32'h0000_0402, 32'h0, 2'b10, 1'b1, 2, 0,
                32'h9876_5432, 32'h0, 1'b0, r, m, a1);
        n_cmp++; if (r !== 32'h0000_9876) begin n_err++; $display("[TB] FAIL half_zext_value: got %h want 00009876", r); end
        run_txn("byte_store3", 1'b1, 32'h0000_0503, 32'h1234_56A5, 2'b01, 1'b0, 0, 0,
                32'h0, 32'h0, 1'b0, r, m, a1);
    endtask

    task automatic test_random();
        logic [31:0] r, a1;
        logic        m;
        logic [31:0] addr;
        for (int i = 0; i < 60; i++) begin
            addr = $urandom;
            if ($urandom_range(0, 3) == 0) addr = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            run_txn($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), addr, $urandom,
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom,
                    1'b0, r, m, a1);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, a1;
        logic        m;
        for (int i = 0; i < 12; i++) begin
            run_txn($sformatf("b2b%0d", i), 1'($urandom_range(0, 1)), $urandom, $urandom,
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom, $urandom,
                    (i != 11), r, m, a1);
        end
        req_valid_i = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        addr_i      = 32'h0000_0600;
        mem_type_i  = 2'b00;
        mem_sign_i  = 1'b0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        n_cmp++; if (mem_req_o !== 1'b1) begin n_err++; $display("[TB] FAIL midrst_in_acc: got %b want 1", mem_req_o); end
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++; if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || rsp_valid_o !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_async: got req=%b addr=%h rsp=%b want 0/0/0", mem_req_o, mem_addr_o, rsp_valid_o); end
        @(posedge clk_i); #1;
        rst_ni      = 1'b1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hCAFE_F00D;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk_i); #1;
            n_cmp++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || mem_req_o !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_late_ack c%0d: got rsp=%b ready=%b req=%b want 0/1/0", c, rsp_valid_o, req_ready_o, mem_req_o); end
        end
        mem_ack_i = 1'b0;
    endtask

    initial begin
        $display("[TB] mem_access_ctrl bench, split=%0d", SPLIT);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_access();
        test_directed();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
